mdu_ctrl: RTL

//  Multi-cycle multiply/divide sequencer for the HI/LO unit. Accepts one MULT/MULTU/DIV/DIVU from EX,

---
 rtl/mdu_ctrl_pkg.sv | 28 ++
 rtl/mdu_ctrl_if.sv | 25 ++
 rtl/mdu_ctrl_div_radix2.sv | 103 ++++++++++
 rtl/mdu_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings, FSM states,
// the divide-by-zero LO pattern and the 32x32->64 product helper.
package mdu_ctrl_pkg;

    localparam logic [1:0] MDU_OP_NONE = 2'b00;
    localparam logic [1:0] MDU_OP_MUL  = 2'b01;
    localparam logic [1:0] MDU_OP_DIV  = 2'b10;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle,
        StMul,
        StDiv,
        StDone
    } mdu_state_t;

    // Sign- or zero-extend both operands to 64 bits; the low 64 bits of the
    // product are then correct for both MULT and MULTU.
    function automatic logic [63:0] mdu_mul(logic [31:0] a, logic [31:0] b, logic is_signed);
        logic [63:0] ax;
        logic [63:0] bx;
        ax = is_signed ? {{32{a[31]}}, a} : {32'b0, a};
        bx = is_signed ? {{32{b[31]}}, b} : {32'b0, b};
        return ax * bx;
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage <-> MDU bundle. The pipeline side is the master, the sequencer the slave.
interface mdu_ctrl_if;

    logic [1:0]  op_i;
    logic        signed_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic        flush_i;
    logic        hold_i;
    logic        stall_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output op_i, signed_i, src_a_i, src_b_i, flush_i, hold_i,
        input  stall_o, hilo_we_o, hi_o, lo_o
    );

    modport slave (
        input  op_i, signed_i, src_a_i, src_b_i, flush_i, hold_i,
        output stall_o, hilo_we_o, hi_o, lo_o
    );

endinterface

// File: rtl/mdu_ctrl_div_radix2.sv
// Restoring radix-2 divider on operand magnitudes, one quotient bit per cycle.
// done_o is high during the final iteration; q_o/r_o then carry the signed-corrected
// result of that iteration so the caller can register it on the same edge.
module div_radix2 #(
    parameter int unsigned DIV_IT = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] q_o,
    output logic [31:0] r_o,
    output logic        done_o
);

    localparam int unsigned CntW = (DIV_IT > 1) ? $clog2(DIV_IT) : 1;

    logic            busy_q, busy_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    // {partial remainder, dividend/quotient} shift register
    logic [63:0]     pr_q, pr_d;
    logic [31:0]     mag_b_q, mag_b_d;
    logic            neg_q_q, neg_q_d;
    logic            neg_r_q, neg_r_d;

    logic [32:0]     rem_sh;
    logic [32:0]     diff;
    logic [63:0]     pr_step;
    logic [31:0]     mag_a;
    logic [31:0]     mag_b;

    // One restoring step plus start/abort bookkeeping
    always_comb begin
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        mag_b_d = mag_b_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;

        // Shifted remainder needs 33 bits: it can exceed 2^32-1 before subtraction.
        rem_sh = pr_q[63:31];
        diff   = rem_sh - {1'b0, mag_b_q};
        if (!diff[32]) begin
            pr_step = {diff[31:0], pr_q[30:0], 1'b1};
        end else begin
            pr_step = {pr_q[62:0], 1'b0};
        end

        mag_a = (signed_i && a_i[31]) ? (~a_i + 32'd1) : a_i;
        mag_b = (signed_i && b_i[31]) ? (~b_i + 32'd1) : b_i;

        if (abort_i) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start_i && !busy_q) begin
            busy_d  = 1'b1;
            cnt_d   = '0;
            pr_d    = {32'b0, mag_a};
            mag_b_d = mag_b;
            neg_q_d = signed_i & (a_i[31] ^ b_i[31]);
            neg_r_d = signed_i & a_i[31];
        end else if (busy_q) begin
            pr_d = pr_step;
            if (cnt_q == CntW'(DIV_IT - 1)) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Result sign correction and completion flag
    always_comb begin
        done_o = busy_q && (cnt_q == CntW'(DIV_IT - 1));
        q_o    = neg_q_q ? (~pr_step[31:0] + 32'd1) : pr_step[31:0];
        r_o    = neg_r_q ? (~pr_step[63:32] + 32'd1) : pr_step[63:32];
    end

    // Divider state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            pr_q    <= '0;
            mag_b_q <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            mag_b_q <= mag_b_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer feeding the HI/LO register.
// Stalls the pipeline while busy and writes HI/LO with a single-cycle pulse.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned DIV_IT  = 32
) (
    input  logic       clk,
    input  logic       resetn,
    mdu_ctrl_if.slave  bus
);

    localparam int unsigned CntW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    mdu_state_t      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [63:0]     prod_q, prod_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;

    logic            stall;
    logic            hilo_we;
    logic            div_start;
    logic [31:0]     div_q;
    logic [31:0]     div_r;
    logic            div_done;

    div_radix2 #(
        .DIV_IT (DIV_IT)
    ) u_div (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (div_start),
        .abort_i  (bus.flush_i),
        .signed_i (bus.signed_i),
        .a_i      (bus.src_a_i),
        .b_i      (bus.src_b_i),
        .q_o      (div_q),
        .r_o      (div_r),
        .done_o   (div_done)
    );

    // Next state, result capture, stall and write-enable generation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        stall     = 1'b0;
        hilo_we   = 1'b0;
        div_start = 1'b0;

        if (bus.flush_i) begin
            // Abort without touching HI/LO; an op offered alongside is dropped.
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.op_i == MDU_OP_MUL) begin
                        stall   = 1'b1;
                        // Product registered at issue; MUL cycles model the retimed multiplier.
                        prod_d  = mdu_mul(bus.src_a_i, bus.src_b_i, bus.signed_i);
                        cnt_d   = '0;
                        state_d = StMul;
                    end else if (bus.op_i == MDU_OP_DIV) begin
                        stall = 1'b1;
                        if (bus.src_b_i == 32'd0) begin
                            hi_d    = bus.src_a_i;
                            lo_d    = DIV0_LO;
                            state_d = StDone;
                        end else begin
                            div_start = 1'b1;
                            state_d   = StDiv;
                        end
                    end
                end
                StMul: begin
                    stall = 1'b1;
                    if (cnt_q == CntW'(MUL_LAT - 1)) begin
                        cnt_d   = '0;
                        hi_d    = prod_q[63:32];
                        lo_d    = prod_q[31:0];
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StDiv: begin
                    stall = 1'b1;
                    if (div_done) begin
                        hi_d    = div_r;
                        lo_d    = div_q;
                        state_d = StDone;
                    end
                end
                StDone: begin
                    if (!bus.hold_i) begin
                        hilo_we = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State, counter, product and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            prod_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.stall_o   = stall;
    assign bus.hilo_we_o = hilo_we;
    assign bus.hi_o      = hi_q;
    assign bus.lo_o      = lo_q;

endmodule
